// File: rtl/cmp_share_arbiter.sv
// Round-robin front end sharing one registered 16-bit magnitude comparator between NREQ
// requesters, with a watchdog and one-hot sanity check on the comparator response.
module cmp_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      rsp_valid,
   output logic                 rsp_gt,
   output logic                 rsp_lt,
   output logic                 rsp_eq,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 cmp_start,
   output logic [15:0]          cmp_ain,
   output logic [15:0]          cmp_bin,
   input  logic                 cmp_greater,
   input  logic                 cmp_less,
   input  logic                 cmp_equal,
   input  logic                 cmp_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   grant;
   logic [IW-1:0]   winner;
   logic [IW-1:0]   cand;
   logic            found;
   logic            accept;
   logic            wait_exit;
   logic [7:0]      wd;
   logic [2:0]      result;
   logic            malformed;

   // Round-robin search starting just after the last winner, so the last winner ranks lowest.
   always_comb begin
      found  = 1'b0;
      winner = ptr;
      cand   = ptr;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(ptr) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign result    = {cmp_greater, cmp_less, cmp_equal};
   assign malformed = (result != 3'b100) && (result != 3'b010) && (result != 3'b001);

   // NOTE: state register only; all next-state and output decoding lives in the always_comb
   // below, which assigns every output a default first so no latch can be inferred.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      wait_exit = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (found) begin
               accept            = 1'b1;
               req_ready[winner] = 1'b1;
               state_nxt         = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            // A done arriving on the final watchdog cycle still wins over the timeout.
            if (cmp_done || (wd == 8'(TIMEOUT))) begin
               wait_exit = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values regardless of statement order within the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= IW'(NREQ - 1);
         grant     <= '0;
         cmp_start <= 1'b0;
         cmp_ain   <= '0;
         cmp_bin   <= '0;
         wd        <= '0;
         rsp_valid <= '0;
         rsp_gt    <= 1'b0;
         rsp_lt    <= 1'b0;
         rsp_eq    <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         cmp_start <= accept;
         rsp_valid <= '0;

         if (accept) begin
            cmp_ain <= req_a[16*int'(winner) +: 16];
            cmp_bin <= req_b[16*int'(winner) +: 16];
            grant   <= winner;
            ptr     <= winner;
         end

         if (state == ISSUE) begin
            wd <= '0;
         end else if (state == WAIT && !wait_exit) begin
            wd <= wd + 8'd1;
         end

         if (wait_exit) begin
            rsp_valid <= NREQ'(1) << grant;
            if (cmp_done) begin
               rsp_gt  <= cmp_greater;
               rsp_lt  <= cmp_less;
               rsp_eq  <= cmp_equal;
               rsp_err <= malformed;
            end else begin
               rsp_gt  <= 1'b0;
               rsp_lt  <= 1'b0;
               rsp_eq  <= 1'b0;
               rsp_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: a comparator stub answers cmp_start, and expected
// responses (requester, flags, due cycle) are queued at acceptance and compared at rsp_valid.
module tb_cmp_share_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 8;

   typedef enum int { M_NORMAL, M_NODONE, M_MALFORM } mode_t;

   typedef struct {
      int         id;
      logic [3:0] flags;   // {gt, lt, eq, err}
      int         due;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [16*NREQ-1:0]  req_a;
   logic [16*NREQ-1:0]  req_b;
   logic [NREQ-1:0]     rsp_valid;
   logic                rsp_gt, rsp_lt, rsp_eq, rsp_err;
   logic                busy;
   logic                cmp_start;
   logic [15:0]         cmp_ain, cmp_bin;
   logic                cmp_greater, cmp_less, cmp_equal, cmp_done;

   mode_t               mode;
   logic                inject_done;
   int                  checks   = 0;
   int                  failures = 0;
   int                  cyc      = 0;
   int                  acc_count = 0;
   logic [NREQ-1:0]     acc_mask = '0;
   logic                check_gap = 1'b0;
   exp_t                sb_q[$];
   int                  grant_q[$];

   cmp_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_gt      (rsp_gt),
      .rsp_lt      (rsp_lt),
      .rsp_eq      (rsp_eq),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .cmp_start   (cmp_start),
      .cmp_ain     (cmp_ain),
      .cmp_bin     (cmp_bin),
      .cmp_greater (cmp_greater),
      .cmp_less    (cmp_less),
      .cmp_equal   (cmp_equal),
      .cmp_done    (cmp_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Comparator stub: registered, done the cycle after start is sampled.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_done    <= 1'b0;
         cmp_greater <= 1'b0;
         cmp_less    <= 1'b0;
         cmp_equal   <= 1'b0;
      end else begin
         cmp_done <= (cmp_start && mode != M_NODONE) || inject_done;
         if (cmp_start) begin
            cmp_greater <= (mode == M_MALFORM) ? 1'b1 : (cmp_ain > cmp_bin);
            cmp_less    <= (mode == M_MALFORM) ? 1'b1 : (cmp_ain < cmp_bin);
            cmp_equal   <= (mode == M_MALFORM) ? 1'b0 : (cmp_ain == cmp_bin);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor on the falling edge, away from the active edge.
   logic        prev_acc = 1'b0;
   logic [15:0] prev_a, prev_b;
   int          last_acc = -1;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         prev_acc = 1'b0;
         acc_mask = '0;
      end else begin
         check("cmp_start", 32'(cmp_start), 32'(prev_acc));
         if (prev_acc) begin
            check("cmp_ain", 32'(cmp_ain), 32'(prev_a));
            check("cmp_bin", 32'(cmp_bin), 32'(prev_b));
         end
         prev_acc = 1'b0;
         check("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
         acc_mask = req_ready & req_valid;
         if (acc_mask != '0) begin
            int   idx;
            exp_t e;
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (acc_mask[i]) idx = i;
            check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            check("busy_at_accept", 32'(busy), 32'd0);
            if (grant_q.size() > 0) check("grant", 32'(idx), 32'(grant_q.pop_front()));
            prev_a = req_a[16*idx +: 16];
            prev_b = req_b[16*idx +: 16];
            e.id = idx;
            case (mode)
               M_NODONE:  begin e.flags = 4'b0001; e.due = cyc + TIMEOUT + 3; end
               M_MALFORM: begin e.flags = 4'b1101; e.due = cyc + 3; end
               default: begin
                  e.flags = {prev_a > prev_b, prev_a < prev_b, prev_a == prev_b, 1'b0};
                  e.due   = cyc + 3;
               end
            endcase
            sb_q.push_back(e);
            if (check_gap && last_acc >= 0) check("accept_gap", 32'(cyc - last_acc), 32'd4);
            last_acc = cyc;
            prev_acc = 1'b1;
            acc_count++;
         end
         if (rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
               check("rsp_flags", 32'({rsp_gt, rsp_lt, rsp_eq, rsp_err}), 32'(e.flags));
               check("rsp_cycle", 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   // Stimulus advances one cycle and withdraws requests the DUT just accepted.
   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc_mask;
   endtask

   task automatic post(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_valid[i]      = 1'b1;
   endtask

   task automatic wait_acc(input int n);
      int start;
      start = acc_count;
      for (int t = 0; t < 200 && acc_count < start + n; t++) tick();
      check("accept_count", 32'(acc_count - start), 32'(n));
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 200 && (sb_q.size() != 0 || busy); t++) tick();
      check("drain_pending", 32'(sb_q.size()), 32'd0);
      check("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmp_start"}, 32'(cmp_start), 32'd0);
      check({tag, "_cmp_ain"}, 32'(cmp_ain), 32'd0);
      check({tag, "_cmp_bin"}, 32'(cmp_bin), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_flags"}, 32'({rsp_gt, rsp_lt, rsp_eq, rsp_err}), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = '0;
      req_a       = '0;
      req_b       = '0;
      mode        = M_NORMAL;
      inject_done = 1'b0;
      #3;
      check_reset_outputs("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single request from requester 2, greater result
      grant_q.push_back(2);
      post(2, 16'h1234, 16'h1233);
      wait_acc(1);
      wait_drain();

      // All four valid from reset with equal operands: grants 0,1,2,3 four cycles apart
      reset_dut();
      check_gap = 1'b1;
      last_acc  = -1;
      for (int i = 0; i < NREQ; i++) grant_q.push_back(i);
      for (int i = 0; i < NREQ; i++) post(i, 16'hFFFF, 16'hFFFF);
      wait_acc(4);
      wait_drain();
      check_gap = 1'b0;

      // Fairness: after 2, pending 1 and 3 go 3 then 1; late 0 follows
      grant_q.push_back(2);
      grant_q.push_back(3);
      grant_q.push_back(1);
      grant_q.push_back(0);
      post(2, 16'h0001, 16'h8000);
      wait_acc(1);
      post(1, 16'h8000, 16'h7FFF);
      post(3, 16'h0000, 16'h0000);
      wait_acc(2);
      post(0, 16'hA5A5, 16'hA5A4);
      wait_acc(1);
      wait_drain();

      // Timeout twice in a row, then a late done must be ignored
      mode = M_NODONE;
      post(1, 16'h0005, 16'h0007);
      post(3, 16'h0007, 16'h0005);
      wait_acc(2);
      wait_drain();
      inject_done = 1'b1;
      tick();
      inject_done = 1'b0;
      tick();
      tick();
      check("late_done_busy", 32'(busy), 32'd0);
      tick();

      // Malformed comparator result
      mode = M_MALFORM;
      post(0, 16'h0001, 16'h0002);
      wait_acc(1);
      wait_drain();

      // Reset while waiting: pending request dropped, priority back to requester 0
      mode = M_NODONE;
      post(2, 16'h1111, 16'h2222);
      wait_acc(1);
      tick();
      tick();
      check("wait_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      mode = M_NORMAL;
      grant_q.push_back(1);
      grant_q.push_back(3);
      post(1, 16'h0010, 16'h0020);
      post(3, 16'h0030, 16'h0030);
      wait_acc(2);
      wait_drain();

      check("grant_queue_left", 32'(grant_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
